// File: rtl/mole_input_encoder.sv
// Whack-a-mole button front end: synchronizes and debounces five mole buttons plus start,
// then serializes mole presses into one hit code per cycle and pulses startGame.
module mole_input_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] moleButtons,
    input  logic       startButton,
    input  logic       gameActive,
    output logic [2:0] userGameInput,
    output logic       startGame
);

    localparam int unsigned N_CH   = 6;
    localparam int unsigned N_MOLE = 5;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]   raw;
    logic [N_CH-1:0]   sync1;
    logic [N_CH-1:0]   sync2;
    logic [N_CH-1:0]   stable;
    logic [N_CH-1:0]   stable_d;
    logic [CNT_W-1:0]  cnt [N_CH];
    logic [N_CH-1:0]   ev;

    logic [N_MOLE-1:0] pending;
    logic [N_MOLE-1:0] cand;
    logic [N_MOLE-1:0] low_bit;
    logic [2:0]        code_next;

    assign raw = {startButton, moleButtons};
    assign ev  = stable & ~stable_d;

    // Two-flop synchronizers, then a per-channel debounce counter that must see the
    // synchronized level disagree with the stable level for DEBOUNCE_CYCLES edges in a row.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < N_CH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Lowest pending-or-new mole wins this cycle; the rest stay pending.
    always_comb begin
        cand      = pending | (ev[N_MOLE-1:0] & {N_MOLE{gameActive}});
        low_bit   = cand & (~cand + N_MOLE'(1));
        code_next = 3'd0;
        for (int i = N_MOLE - 1; i >= 0; i--) begin
            if (cand[i]) begin
                code_next = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending       <= '0;
            userGameInput <= 3'd0;
            startGame     <= 1'b0;
        end else begin
            startGame <= ev[N_CH-1] & ~gameActive;
            if (gameActive) begin
                pending       <= cand & ~low_bit;
                userGameInput <= code_next;
            end else begin
                pending       <= '0;
                userGameInput <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_mole_input_encoder.sv
// Directed bench for mole_input_encoder with a short debounce window (4 cycles).
module tb_mole_input_encoder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] moleButtons = 5'd0;
    logic       startButton = 1'b0;
    logic       gameActive = 1'b0;
    logic [2:0] userGameInput;
    logic       startGame;

    int vec_cnt = 0;
    int err_cnt = 0;

    mole_input_encoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .moleButtons  (moleButtons),
        .startButton  (startButton),
        .gameActive   (gameActive),
        .userGameInput(userGameInput),
        .startGame    (startGame)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            moleButtons = 5'(c * 7);
            startButton = c[0];
            tick();
            vec_cnt++;
            if (userGameInput !== 3'd0 || startGame !== 1'b0) begin
                err_cnt++;
                $display("FAIL reset_hold cycle %0d: code=%0d start=%0b expected 0/0", c, userGameInput, startGame);
            end
        end
        moleButtons = 5'd0;
        startButton = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            vec_cnt++;
            if (userGameInput !== 3'd0 || startGame !== 1'b0) begin
                err_cnt++;
                $display("FAIL reset_release cycle %0d: code=%0d start=%0b expected 0/0", c, userGameInput, startGame);
            end
        end
    endtask

    task automatic idle_check(input string name, input int n);
        for (int c = 1; c <= n; c++) begin
            tick();
            vec_cnt++;
            if (userGameInput !== 3'd0 || startGame !== 1'b0) begin
                err_cnt++;
                $display("FAIL %s cycle %0d: code=%0d start=%0b expected 0/0", name, c, userGameInput, startGame);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [2:0] exp;
        gameActive  = 1'b1;
        moleButtons = 5'b00100;
        for (int c = 1; c <= 30; c++) begin
            tick();
            exp = (c == 7) ? 3'd3 : 3'd0;
            vec_cnt++;
            if (userGameInput !== exp) begin
                err_cnt++;
                $display("FAIL clean_press cycle %0d: code=%0d expected %0d", c, userGameInput, exp);
            end
        end
        moleButtons = 5'd0;
        idle_check("clean_release", 15);
    endtask

    task automatic test_bounce();
        logic [2:0] exp;
        for (int c = 0; c < 20; c++) begin
            moleButtons = ((c / 2) % 2 == 0) ? 5'b00001 : 5'b00000;
            tick();
            vec_cnt++;
            if (userGameInput !== 3'd0) begin
                err_cnt++;
                $display("FAIL bounce_phase cycle %0d: code=%0d expected 0", c, userGameInput);
            end
        end
        moleButtons = 5'b00001;
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp = (c == 7) ? 3'd1 : 3'd0;
            vec_cnt++;
            if (userGameInput !== exp) begin
                err_cnt++;
                $display("FAIL bounce_settle cycle %0d: code=%0d expected %0d", c, userGameInput, exp);
            end
        end
        moleButtons = 5'd0;
        idle_check("bounce_release", 15);
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        moleButtons = 5'b01001;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) moleButtons = 5'b11001;
            case (c)
                7:       exp = 3'd1;
                8:       exp = 3'd4;
                9:       exp = 3'd5;
                default: exp = 3'd0;
            endcase
            vec_cnt++;
            if (userGameInput !== exp) begin
                err_cnt++;
                $display("FAIL back_to_back cycle %0d: code=%0d expected %0d", c, userGameInput, exp);
            end
        end
        moleButtons = 5'd0;
        idle_check("b2b_release", 15);
    endtask

    task automatic test_start_inactive();
        logic exp;
        gameActive  = 1'b0;
        moleButtons = 5'b00010;
        idle_check("inactive_mole", 15);
        moleButtons = 5'd0;
        idle_check("inactive_release", 15);
        startButton = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp = (c == 7);
            vec_cnt++;
            if (startGame !== exp || userGameInput !== 3'd0) begin
                err_cnt++;
                $display("FAIL start_pulse cycle %0d: start=%0b code=%0d expected %0b/0", c, startGame, userGameInput, exp);
            end
        end
        startButton = 1'b0;
        idle_check("start_release", 15);
        gameActive  = 1'b1;
        startButton = 1'b1;
        idle_check("start_in_play", 20);
        startButton = 1'b0;
        idle_check("start_in_play_release", 15);
    endtask

    task automatic test_flush();
        gameActive  = 1'b1;
        moleButtons = 5'b00111;
        for (int c = 1; c <= 7; c++) begin
            tick();
            vec_cnt++;
            if (userGameInput !== ((c == 7) ? 3'd1 : 3'd0)) begin
                err_cnt++;
                $display("FAIL flush_first cycle %0d: code=%0d expected %0d", c, userGameInput, (c == 7) ? 1 : 0);
            end
        end
        gameActive = 1'b0;
        idle_check("flush_drop", 5);
        gameActive = 1'b1;
        idle_check("flush_restore", 10);
        moleButtons = 5'd0;
        idle_check("flush_release", 15);
    endtask

    task automatic test_mid_debounce_reset();
        logic [2:0] exp;
        gameActive  = 1'b1;
        moleButtons = 5'b00001;
        for (int c = 1; c <= 4; c++) tick();
        reset = 1'b0;
        #1;
        vec_cnt++;
        if (userGameInput !== 3'd0 || startGame !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_reset: code=%0d start=%0b expected 0/0", userGameInput, startGame);
        end
        idle_check("mid_reset_hold", 3);
        reset = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp = (c == 7) ? 3'd1 : 3'd0;
            vec_cnt++;
            if (userGameInput !== exp) begin
                err_cnt++;
                $display("FAIL mid_reset_repress cycle %0d: code=%0d expected %0d", c, userGameInput, exp);
            end
        end
        moleButtons = 5'd0;
        idle_check("mid_reset_release", 15);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_back_to_back();
        test_start_inactive();
        test_flush();
        test_mid_debounce_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mole_input_encoder.md
# mole_input_encoder

Front-end input block for the whack-a-mole game. It synchronizes and debounces the five raw mole buttons and the start button, then encodes mole presses into the 3-bit `userGameInput` hit code consumed by the main game datapath. It also produces the one-cycle `startGame` pulse. When several presses are pending, it serializes them so the datapath sees at most one hit code per cycle and never drops a press made during active play.

## Interface

- `DEBOUNCE_CYCLES`, default 500000: number of consecutive cycles a synchronized input must differ from its debounced value before that value flips (10 ms at 50 MHz); minimum 2.
- `clock` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset; low clears all state immediately.
- `moleButtons` input 5: raw, asynchronous, active-high mole buttons; bit i is mole i+1.
- `startButton` input 1: raw, asynchronous, active-high start button.
- `gameActive` input 1: high while the game FSM is in INGAME; synchronous to `clock`.
- `userGameInput` output 3: hit code; 3'd0 means no hit, 3'd1..3'd5 means mole 1..5 was hit this cycle; codes 6 and 7 never appear.
- `startGame` output 1: one-cycle pulse on a debounced start press.

## Operation

- **Synchronizer:** each of the 6 raw inputs passes through a 2-flop synchronizer, giving `sync[i]`.
- **Debouncer (per channel):**
  - Each channel has a debounced level `stable[i]` and a counter sized ceil(log2(DEBOUNCE_CYCLES)) bits.
  - If `sync == stable`: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: `stable <= sync` and counter <= 0.
  - Else: counter <= counter+1.
  - Any bounce back to `stable` restarts the count.
- **Press event:** `ev[i] = stable[i] & ~stable_d[i]`, where `stable_d` is the one-cycle-delayed copy. Releases generate nothing. Holding a button generates exactly one event.
- **Mole arbitration:**
  - Candidate set is `cand = pending | (ev[4:0] & {5{gameActive}})`.
  - If `cand` is nonzero and `gameActive` = 1: the lowest set bit k is selected. At the next edge `userGameInput` <= k+1 and `pending` <= `cand` with bit k cleared.
  - If `cand` is zero: `userGameInput` <= 0.
  - A new event on a bit already pending merges with it; no duplicate code is produced.
- **Inactive game:** while `gameActive` = 0, at each edge `pending` <= 0 and `userGameInput` <= 0. Mole events are discarded.
- **Start:** at the edge after `ev[5]`, `startGame` <= 1 if `gameActive` = 0, else `startGame` <= 0. `startGame` is otherwise 0. Start presses during play are ignored.
- **Reset:** `reset` low clears `userGameInput`, `startGame`, `pending`, all synchronizer flops, `stable`, `stable_d` and all counters to 0.
  - Reset mid-debounce abandons the count.
  - A button still held after reset deassertion is debounced afresh and yields one event.

## Timing

- Reset values of all outputs are 0. Reset takes effect asynchronously; release is sampled at the next rising edge.
- Latency from a clean raw edge:
  - Raw rises before edge 1.
  - `sync` = 1 after edge 2.
  - `stable` rises at edge 2+DEBOUNCE_CYCLES.
  - `userGameInput` or `startGame` is valid after edge 3+DEBOUNCE_CYCLES, provided `pending` is empty.
- Each nonzero hit code and each `startGame` pulse lasts exactly one cycle.
- N simultaneous mole events produce N codes on N consecutive cycles, in ascending mole order.
- Throughput is 1 code per cycle. Pending depth is bounded at 5, so nothing is lost while `gameActive` = 1.
- A `gameActive` falling edge flushes `pending`: the output is 0 from the next edge onward.

## Test plan

- **Reset:** hold `reset` = 0 with buttons toggling -> `userGameInput` = 0 and `startGame` = 0 throughout; after release with all inputs 0, outputs stay 0.
- **Clean press (DEBOUNCE_CYCLES = 4, `gameActive` = 1):** `moleButtons[2]` rises before edge 1 and is held 30 cycles -> `userGameInput` = 3'd3 only after edge 7, then 0. Release produces no code.
- **Bounce:** `moleButtons[0]` toggles every 2 cycles for 20 cycles, then holds at 1 -> exactly one 3'd1, appearing after edge 3+4 counted from the final rise.
- **Simultaneous presses:** `moleButtons[0]` and `moleButtons[3]` rise together -> 3'd1 and 3'd4 on consecutive cycles; a third press of mole 5 arriving while mole 4 is pending yields 3'd5 on the following cycle.
- **Start and inactive game:** `gameActive` = 0 and a mole press -> no code. A start press -> `startGame` = 1 for one cycle. A start press with `gameActive` = 1 -> no pulse.
- **Flush and mid-debounce reset:**
  - Drop `gameActive` with two events pending -> `userGameInput` = 0 from the next edge.
  - Assert `reset` at counter value 2 while the button is held -> no event, then after release exactly one event at 3+4 edges.
